si5324_i2c_init: RTL



---
 rtl/si5324_pkg.sv | 26 ++
 rtl/i2c_byte_master.sv | 136 +++++++++++++
 rtl/si5324_i2c_init.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/si5324_pkg.sv
// Shared types and constants for the Si5324 power-up I2C sequencer.
package si5324_pkg;

  typedef enum logic [2:0] {
    RST_HOLD, RST_WAIT, MUX_WR, REG_WR, NEXT, DONE, ERR
  } top_state_e;

  typedef enum logic [2:0] {
    E_IDLE, E_START, E_BIT, E_STOP, E_GAP
  } eng_state_e;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_STOP  = 2'd2
  } i2c_cmd_e;

  localparam logic [6:0] DEF_MUX_ADDR = 7'h74;
  localparam logic [7:0] DEF_MUX_CHAN = 8'h10;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h68;

  function automatic logic [7:0] addr_wr(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_byte_master.sv
// Quarter-period I2C engine: START, byte+ACK and STOP (with bus-idle gap)
// commands over open-drain SCL/SDA, honouring slave clock stretching.
module i2c_byte_master
  import si5324_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] byte_i,
  output logic       rsp_valid_o,
  output logic       nack_o,
  output logic       scl_oe_o,
  input  logic       scl_i,
  output logic       sda_oe_o,
  input  logic       sda_i
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  eng_state_e       state_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       qtr_q;
  logic [3:0]       bit_q;
  logic [7:0]       shift_q;
  logic             scl_oe_q, sda_oe_q, rsp_valid_q, nack_q;
  logic [1:0]       scl_sync_q, sda_sync_q;
  logic             scl_s, sda_s, stretch, tick;

  assign scl_s   = scl_sync_q[1];
  assign sda_s   = sda_sync_q[1];
  // Released SCL still reading low means a slave is stretching the clock.
  assign stretch = !scl_oe_q && !scl_s;
  assign tick    = (state_q != E_IDLE) && !stretch && (div_q == DIV_W'(CLK_DIV - 1));

  assign cmd_ready_o = (state_q == E_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign nack_o      = nack_q;
  assign scl_oe_o    = scl_oe_q;
  assign sda_oe_o    = sda_oe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= E_IDLE;
      div_q       <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 4'd0;
      shift_q     <= 8'h00;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      nack_q      <= 1'b0;
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
    end else begin
      scl_sync_q  <= {scl_sync_q[0], scl_i};
      sda_sync_q  <= {sda_sync_q[0], sda_i};
      rsp_valid_q <= 1'b0;
      if (state_q == E_IDLE || tick) div_q <= '0;
      else if (!stretch)             div_q <= div_q + 1'b1;

      case (state_q)
        E_IDLE: begin
          if (cmd_valid_i) begin
            qtr_q   <= 2'd0;
            bit_q   <= 4'd0;
            shift_q <= byte_i;
            case (cmd_i)
              CMD_START: state_q <= E_START;
              CMD_WRITE: begin state_q <= E_BIT;  scl_oe_q <= 1'b1; end
              default:   begin state_q <= E_STOP; scl_oe_q <= 1'b1; end
            endcase
          end
        end
        E_START: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd0) begin
              sda_oe_q <= 1'b1;
            end else begin
              state_q     <= E_IDLE;
              rsp_valid_q <= 1'b1;
              nack_q      <= 1'b0;
            end
          end
        end
        E_BIT: begin
          // Bit 8 is the ACK slot: SDA released, sampled mid SCL-high.
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            case (qtr_q)
              2'd0: sda_oe_q <= (bit_q == 4'd8) ? 1'b0 : ~shift_q[7];
              2'd1: scl_oe_q <= 1'b0;
              2'd2: if (bit_q == 4'd8) nack_q <= sda_s;
              default: begin
                if (bit_q == 4'd8) begin
                  state_q     <= E_IDLE;
                  rsp_valid_q <= 1'b1;
                end else begin
                  bit_q    <= bit_q + 4'd1;
                  shift_q  <= {shift_q[6:0], 1'b0};
                  scl_oe_q <= 1'b1;
                end
              end
            endcase
          end
        end
        E_STOP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            case (qtr_q)
              2'd0:    sda_oe_q <= 1'b1;
              2'd1:    scl_oe_q <= 1'b0;
              2'd2:    sda_oe_q <= 1'b0;
              default: state_q  <= E_GAP;
            endcase
          end
        end
        E_GAP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              state_q     <= E_IDLE;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= E_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/si5324_i2c_init.sv
// Si5324 power-up sequencer: reset release, PCA9548 channel select, then
// one I2C register write per ROM entry; done/error are sticky until start.
module si5324_i2c_init
  import si5324_pkg::*;
#(
  parameter int         CLK_DIV     = 250,
  parameter int         RST_CYCLES  = 20000,
  parameter int         WAIT_CYCLES = 50000,
  parameter logic [6:0] MUX_ADDR    = DEF_MUX_ADDR,
  parameter logic [7:0] MUX_CHAN    = DEF_MUX_CHAN,
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         NUM_REGS    = 32
) (
  input  logic        clk100,
  input  logic        sys_rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        scl_oe,
  input  logic        scl_i,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        i2c_rst_n,
  output logic        si5324_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  top_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       step_q;
  logic             pending_q, nack_seen_q, cmd_valid_q;
  logic [7:0]       reg_q, val_q, rom_addr_q;
  logic             rst_n_q, busy_q, done_q, error_q;

  logic       cmd_ready, rsp_valid, rsp_nack;
  logic [1:0] cmd;
  logic [7:0] cmd_byte;
  logic [2:0] stop_step;

  assign rom_addr     = rom_addr_q;
  assign i2c_rst_n    = rst_n_q;
  assign si5324_rst_n = rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

  // step 0 is START, the last step STOP, everything between a byte write.
  always_comb begin
    stop_step = (state_q == MUX_WR) ? 3'd3 : 3'd4;
    cmd       = CMD_WRITE;
    if (step_q == 3'd0)           cmd = CMD_START;
    else if (step_q == stop_step) cmd = CMD_STOP;
    case (step_q)
      3'd1:    cmd_byte = (state_q == MUX_WR) ? addr_wr(MUX_ADDR) : addr_wr(DEV_ADDR);
      3'd2:    cmd_byte = (state_q == MUX_WR) ? MUX_CHAN : reg_q;
      3'd3:    cmd_byte = val_q;
      default: cmd_byte = 8'h00;
    endcase
  end

  i2c_byte_master #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk_i       (clk100),
    .rst_i       (sys_rst),
    .cmd_valid_i (cmd_valid_q),
    .cmd_ready_o (cmd_ready),
    .cmd_i       (cmd),
    .byte_i      (cmd_byte),
    .rsp_valid_o (rsp_valid),
    .nack_o      (rsp_nack),
    .scl_oe_o    (scl_oe),
    .scl_i       (scl_i),
    .sda_oe_o    (sda_oe),
    .sda_i       (sda_i)
  );

  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= RST_HOLD;
      cnt_q       <= '0;
      step_q      <= 3'd0;
      pending_q   <= 1'b0;
      nack_seen_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      reg_q       <= 8'h00;
      val_q       <= 8'h00;
      rom_addr_q  <= 8'h00;
      rst_n_q     <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (cmd_valid_q && cmd_ready) begin
        cmd_valid_q <= 1'b0;
        // ROM entry is latched as the START is accepted.
        if (step_q == 3'd0) begin
          reg_q <= rom_data[15:8];
          val_q <= rom_data[7:0];
        end
      end

      case (state_q)
        RST_HOLD: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            cnt_q   <= '0;
            rst_n_q <= 1'b1;
            state_q <= RST_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RST_WAIT: begin
          if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            cnt_q       <= '0;
            step_q      <= 3'd0;
            pending_q   <= 1'b0;
            nack_seen_q <= 1'b0;
            state_q     <= MUX_WR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MUX_WR, REG_WR: begin
          if (!pending_q) begin
            cmd_valid_q <= 1'b1;
            pending_q   <= 1'b1;
          end else if (rsp_valid) begin
            pending_q <= 1'b0;
            if (step_q == stop_step) begin
              step_q <= 3'd0;
              if (nack_seen_q) begin
                state_q <= ERR;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
              end else if (state_q == MUX_WR) begin
                state_q <= REG_WR;
              end else begin
                state_q <= NEXT;
              end
            end else if (cmd == CMD_WRITE && rsp_nack) begin
              nack_seen_q <= 1'b1;
              step_q      <= stop_step;
            end else begin
              step_q <= step_q + 3'd1;
            end
          end
        end
        NEXT: begin
          if (rom_addr_q == 8'(NUM_REGS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            rom_addr_q <= rom_addr_q + 8'd1;
            state_q    <= REG_WR;
          end
        end
        DONE, ERR: begin
          if (start) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            rom_addr_q  <= 8'h00;
            step_q      <= 3'd0;
            pending_q   <= 1'b0;
            nack_seen_q <= 1'b0;
            state_q     <= MUX_WR;
          end
        end
        default: state_q <= RST_HOLD;
      endcase
    end
  end

endmodule
